// File: rtl/prbs13_pkg.sv
// Shared PRBS13 constants, state type and LFSR next-bit helper.
// Polynomial x^13+x^12+x^11+x^8+1, Fibonacci form.
package prbs13_pkg;

  localparam int LFSR_W = 13;
  localparam int TAP_A  = 12;
  localparam int TAP_B  = 11;
  localparam int TAP_C  = 10;
  localparam int TAP_D  = 7;

  localparam logic [LFSR_W-1:0] ALL_ONES = 13'h1FFF;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  function automatic logic next_bit(
    input logic [LFSR_W-1:0] sr
  );
    return sr[TAP_A] ^ sr[TAP_B] ^
           sr[TAP_C] ^ sr[TAP_D];
  endfunction

endpackage

// File: rtl/prbs13_lock_mon.sv
// Loss-of-lock monitor: counts errors per window
// of valid bits and flags loss at the threshold.
module prbs13_lock_mon
  import prbs13_pkg::*;
#(
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic valid,
  input  logic err,
  input  logic locked,
  output logic loss
);

  localparam int WC_W = $clog2(WINDOW);
  localparam int WE_W = $clog2(LOSS_THRESH + 1);

  logic [WC_W-1:0] win_cnt;
  logic [WE_W-1:0] win_err;
  logic            wrap;

  assign wrap = win_cnt == WC_W'(WINDOW - 1);

  assign loss = locked && valid && err &&
                (win_err == WE_W'(LOSS_THRESH - 1));

  // Held clear outside LOCKED so each lock starts a fresh window.
  always_ff @(posedge clk) begin
    if (!reset) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (!locked) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (valid) begin
      win_cnt <= win_cnt + 1'b1;
      if (loss || wrap)
        win_err <= '0;
      else if (err)
        win_err <= win_err + 1'b1;
    end
  end

endmodule

// File: rtl/prbs13_checker.sv
// PRBS13 receive checker: self-synchronises, locks,
// flywheels on prediction and counts bit errors.
module prbs13_checker
  import prbs13_pkg::*;
#(
  parameter int LOCK_GOOD   = 16,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             bit_err,
  output logic             lock_lost,
  output logic             period_tick,
  output logic [CNT_W-1:0] err_count
);

  localparam int FILL_W  = $clog2(LFSR_W + 1);
  localparam int MATCH_W = $clog2(LOCK_GOOD + 1);

  state_e state, state_d;

  logic [LFSR_W-1:0]  sr, sr_d;
  logic [FILL_W-1:0]  fill_cnt;
  logic [MATCH_W-1:0] match_cnt;

  logic expected, mismatch, filled;
  logic hit, loss;
  logic bit_err_d, lock_lost_d, period_tick_d;

  assign expected = next_bit(sr);
  assign mismatch = bit_in ^ expected;
  assign filled   = fill_cnt == FILL_W'(LFSR_W);
  // A match on an all-zero register is lockup, not sync.
  assign hit      = filled && !mismatch &&
                    (sr != '0);
  assign locked   = state == LOCKED;

  prbs13_lock_mon #(
    .WINDOW      (WINDOW),
    .LOSS_THRESH (LOSS_THRESH)
  ) u_lock_mon (
    .clk    (clk),
    .reset  (reset),
    .valid  (bit_valid),
    .err    (mismatch),
    .locked (locked),
    .loss   (loss)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= SEARCH;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (bit_valid) begin
      unique case (state)
        SEARCH:
          if (hit && match_cnt ==
              MATCH_W'(LOCK_GOOD - 1))
            state_d = LOCKED;
        LOCKED:
          if (loss) state_d = SEARCH;
      endcase
    end
  end

  always_comb begin
    sr_d = locked ?
           {sr[LFSR_W-2:0], expected} :
           {sr[LFSR_W-2:0], bit_in};
    bit_err_d     = bit_valid && locked && mismatch;
    lock_lost_d   = loss;
    period_tick_d = bit_valid && locked &&
                    (sr_d == ALL_ONES);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr          <= '0;
      fill_cnt    <= '0;
      match_cnt   <= '0;
      bit_err     <= 1'b0;
      lock_lost   <= 1'b0;
      period_tick <= 1'b0;
      err_count   <= '0;
    end else begin
      bit_err     <= bit_err_d;
      lock_lost   <= lock_lost_d;
      period_tick <= period_tick_d;
      if (bit_valid) begin
        sr <= sr_d;
        if (!locked) begin
          if (!filled)
            fill_cnt <= fill_cnt + 1'b1;
          else if (hit)
            match_cnt <= match_cnt + 1'b1;
          else
            match_cnt <= '0;
        end else if (loss) begin
          fill_cnt  <= '0;
          match_cnt <= '0;
        end
      end
      if (clear_cnt)
        err_count <= '0;
      else if (bit_err_d && err_count != '1)
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_prbs13_checker.sv
// Randomized bench for prbs13_checker against a
// queue-based behavioural model of the checker.
module tb_prbs13_checker;

  localparam int CW   = 6;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          bit_in    = 1'b0;
  logic          bit_valid = 1'b0;
  logic          clear_cnt = 1'b0;
  logic          locked;
  logic          bit_err;
  logic          lock_lost;
  logic          period_tick;
  logic [CW-1:0] err_count;

  always #5 clk = ~clk;

  prbs13_checker #(.CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .clear_cnt   (clear_cnt),
    .locked      (locked),
    .bit_err     (bit_err),
    .lock_lost   (lock_lost),
    .period_tick (period_tick),
    .err_count   (err_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag,
                       logic [31:0] obs,
                       logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  // transmit-side generator, seeded all ones
  logic [12:0] tx = 13'h1FFF;

  function automatic bit gen();
    bit nb;
    nb = tx[12] ^ tx[11] ^ tx[10] ^ tx[7];
    tx = {tx[11:0], nb};
    return nb;
  endfunction

  // model: last 13 register bits, index 0 oldest
  bit m_hist[$];
  bit m_lk, m_err, m_lost, m_tick;
  int m_fill, m_run, m_wpos, m_werr, m_cnt;

  function automatic void m_reset();
    m_hist = {};
    repeat (13) m_hist.push_back(1'b0);
    m_lk = 0; m_err = 0; m_lost = 0; m_tick = 0;
    m_fill = 0; m_run = 0; m_wpos = 0;
    m_werr = 0; m_cnt = 0;
  endfunction

  function automatic void m_step(bit v, bit b,
                                 bit clr);
    bit pred, zero, ones;
    m_err = 0; m_lost = 0; m_tick = 0;
    if (v) begin
      pred = m_hist[0] ^ m_hist[1] ^
             m_hist[2] ^ m_hist[5];
      zero = 1; ones = 1;
      foreach (m_hist[i]) if (m_hist[i]) zero = 0;
      void'(m_hist.pop_front());
      if (!m_lk) begin
        m_hist.push_back(b);
        if (m_fill < 13) m_fill++;
        else if (b == pred && !zero) m_run++;
        else m_run = 0;
        if (m_run == 16) begin
          m_lk = 1; m_wpos = 0; m_werr = 0;
        end
      end else begin
        m_hist.push_back(pred);
        foreach (m_hist[i]) if (!m_hist[i]) ones = 0;
        m_tick = ones;
        if (b != pred) begin
          m_err = 1; m_werr++;
          if (m_cnt < MAXC) m_cnt++;
        end
        if (m_werr >= 8) begin
          m_lk = 0; m_lost = 1;
          m_fill = 0; m_run = 0;
        end else begin
          m_wpos++;
          if (m_wpos == 64) begin
            m_wpos = 0; m_werr = 0;
          end
        end
      end
    end
    if (clr) m_cnt = 0;
  endfunction

  int vbits = 0, sk = 0, nticks = 0;
  int last_tick = -1, tick_gap = 0, nbiterr = 0;

  task automatic cyc(bit v, bit b, bit clr);
    bit_valid = v; bit_in = b; clear_cnt = clr;
    @(posedge clk);
    if (!reset) m_reset();
    else m_step(v, b, clr);
    #1;
    check("locked", locked, m_lk);
    check("bit_err", bit_err, m_err);
    check("lock_lost", lock_lost, m_lost);
    check("period_tick", period_tick, m_tick);
    check("err_count", err_count, m_cnt);
    if (v) vbits++;
    if (period_tick === 1'b1) begin
      if (last_tick >= 0) tick_gap = vbits - last_tick;
      last_tick = vbits;
      nticks++;
    end
    if (bit_err === 1'b1) nbiterr++;
    bit_valid = 0; clear_cnt = 0;
  endtask

  task automatic send(bit b, bit clr, int gap);
    cyc(1'b1, b, clr);
    sk++;
    repeat (gap) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic relock(string tag, int want);
    int n = 0;
    while (locked !== 1'b1 && n < 100) begin
      send(gen(), 1'b0, $urandom_range(0, 2));
      n++;
    end
    check(tag, n, want);
    sk = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    check("rst_locked", locked, 0);
    check("rst_count", err_count, 0);
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    bit any, b;
    int nb, inj, rounds;
    m_reset();
    do_reset();

    for (int i = 1; i <= 29; i++) begin
      send(gen(), 1'b0, 3);
      if (i == 28) check("pre_lock", locked, 0);
    end
    check("lock29", locked, 1);
    sk = 0;
    for (int i = 0; i < 16450; i++) begin
      b = gen();
      if (sk == 100 || sk == 300 || sk == 500) b = ~b;
      send(b, 1'b0, $urandom_range(0, 1));
    end
    check("ticks", nticks, 2);
    check("tick_gap", tick_gap, 8191);
    check("single_pulses", nbiterr, 3);
    check("single_count", err_count, 3);
    check("single_locked", locked, 1);

    send(gen(), 1'b1, 1);
    check("clear", err_count, 0);
    while (sk % 64 != 0) send(gen(), 1'b0, 0);
    nb = 0;
    while (lock_lost !== 1'b1 && nb < 64) begin
      send(~gen(), 1'b0, 0);
      nb++;
    end
    check("burst_len", nb, 8);
    check("loss_unlocked", locked, 0);
    check("loss_count", err_count, 8);
    relock("relock", 29);
    check("relock_count", err_count, 8);

    do_reset();
    any = 0;
    repeat (200) begin
      send(1'b0, 1'b0, $urandom_range(0, 1));
      any |= locked;
    end
    check("zero_nolock", any, 0);
    for (int i = 0; i < 300; i++) begin
      b = gen();
      if (i % 10 == 9) b = ~b;
      send(b, 1'b0, $urandom_range(0, 1));
      any |= locked;
    end
    check("garbage_nolock", any, 0);

    do_reset();
    relock("sat_lock", 29);
    inj = 0; rounds = 0;
    while (inj < MAXC + 5 && rounds < 40) begin
      nb = 0;
      while (lock_lost !== 1'b1 && nb < 64) begin
        send(~gen(), 1'b0, 0);
        nb++; inj++;
      end
      relock("sat_relock", 29);
      rounds++;
    end
    check("saturate", err_count, MAXC);
    send(~gen(), 1'b1, 0);
    check("clr_err_pulse", bit_err, 1);
    check("clr_wins", err_count, 0);

    send(~gen(), 1'b0, 0);
    send(~gen(), 1'b0, 0);
    check("pre_rst_count", err_count, 2);
    reset = 1'b0;
    cyc(1'b1, ~gen(), 1'b0);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_count", err_count, 0);
    check("mid_rst_err", bit_err, 0);
    check("mid_rst_lost", lock_lost, 0);
    reset = 1'b1;
    relock("rst_relock", 29);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
